subtracter_32bit: RTL and testbench



---
 rtl/subtracter_32bit_if.sv | 36 +++
 rtl/subtracter_32bit.sv | 56 +++++
 tb/tb_subtracter_32bit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/subtracter_32bit_if.sv
// Operand/result bundle for the registered subtract unit.
// The master drives operands; the slave returns the registered difference and flags.
interface subtracter_32bit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH:0]   result;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        input  out_valid,
        input  result,
        input  zero,
        input  negative,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        output out_valid,
        output result,
        output zero,
        output negative,
        output overflow
    );
endinterface

// File: rtl/subtracter_32bit.sv
// Single-cycle registered subtractor: result = {borrow, a - b} plus zero/negative/overflow.
// Outputs update only on a sampled in_valid; out_valid tracks in_valid one cycle late.
module subtracter_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    subtracter_32bit_if.slave bus
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero_d;
    logic             negative_d;
    logic             overflow_d;

    logic             out_valid_q;
    logic [WIDTH:0]   result_q;
    logic             zero_q;
    logic             negative_q;
    logic             overflow_q;

    // a + ~b + 1; the carry-out is the inverse of the unsigned borrow.
    always_comb begin
        sum        = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        diff       = sum[WIDTH-1:0];
        borrow     = ~sum[WIDTH];
        zero_d     = (diff == '0);
        negative_d = diff[WIDTH-1];
        overflow_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q   <= {borrow, diff};
                zero_q     <= zero_d;
                negative_q <= negative_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_subtracter_32bit.sv
// Scoreboard bench for subtracter_32bit: directed vectors plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_subtracter_32bit;
    typedef struct packed {
        logic [32:0] result;
        logic        zero;
        logic        negative;
        logic        overflow;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t scb[$];
    exp_t last;

    subtracter_32bit_if #(.WIDTH(32)) bus ();

    subtracter_32bit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint sd;
        longint lim;
        sa         = longint'($signed(a));
        sbv        = longint'($signed(b));
        sd         = sa - sbv;
        lim        = 64'sd2147483647;
        e.result   = {(a < b), a - b};
        e.zero     = (a == b);
        e.negative = e.result[31];
        e.overflow = (sd > lim) || (sd < -lim - 64'sd1);
        return e;
    endfunction

    function automatic exp_t mk(input logic [32:0] r, input logic z, input logic n,
                                input logic o);
        exp_t e;
        e.result   = r;
        e.zero     = z;
        e.negative = n;
        e.overflow = o;
        return e;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        exp_t got;
        got      = {bus.result, bus.zero, bus.negative, bus.overflow};
        n_checks = n_checks + 1;
        if (got !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got result=%h z=%b n=%b o=%b, expected result=%h z=%b n=%b o=%b",
                     name, got.result, got.zero, got.negative, got.overflow,
                     e.result, e.zero, e.negative, e.overflow);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    // Called at a rising edge; returns at the edge that samples the operands.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        scb.push_back(e);
    endtask

    task automatic issue_rand(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, model(a, b));
    endtask

    task automatic idle();
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        @(posedge clk);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    // Monitor: away from the active edge, pop on out_valid, else expect held outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (scb.size() == 0) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL unexpected_valid: got out_valid=1, expected 0 (no pending op)");
                end else begin
                    last = scb.pop_front();
                    check_out("result", last);
                end
            end else begin
                n_checks = n_checks + 1;
                if (scb.size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL latency: got out_valid=0, expected 1 (%0d pending)",
                             scb.size());
                end
                check_out("hold", last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks     = 0;
        n_fail       = 0;
        last         = '0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        rst          = 1'b1;
        #1;
        check_out("reset_init", '0);
        check_bit("reset_init_valid", bus.out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        repeat (2) idle();

        // Directed vectors.
        issue(32'h1101_1011, 32'h1011_1101, mk(33'h0_00EF_FF10, 1'b0, 1'b0, 1'b0));
        issue(32'h0000_0000, 32'h0000_0001, mk(33'h1_FFFF_FFFF, 1'b0, 1'b1, 1'b0));
        idle();
        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, mk(33'h0_0000_0000, 1'b1, 1'b0, 1'b0));
        issue(32'h8000_0000, 32'h0000_0001, mk(33'h0_7FFF_FFFF, 1'b0, 1'b0, 1'b1));
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, mk(33'h1_8000_0000, 1'b0, 1'b1, 1'b1));
        // Back-to-back then drop in_valid; monitor verifies the hold.
        issue(32'h0000_0010, 32'h0000_0003, mk(33'h0_0000_000D, 1'b0, 1'b0, 1'b0));
        issue(32'h0000_0003, 32'h0000_0010, mk(33'h1_FFFF_FFF3, 1'b0, 1'b1, 1'b0));
        issue(32'hFFFF_FFFF, 32'h0000_0001, mk(33'h0_FFFF_FFFE, 1'b0, 1'b1, 1'b0));
        repeat (3) idle();

        // Asynchronous reset between edges while out_valid is high.
        issue(32'h1234_5678, 32'h0000_0001, mk(33'h0_1234_5677, 1'b0, 1'b0, 1'b0));
        #3;
        check_bit("pre_reset_valid", bus.out_valid, 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_out("async_reset", '0);
        check_bit("async_reset_valid", bus.out_valid, 1'b0);
        scb.delete();
        last = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        repeat (3) idle();

        // Randomized traffic with random gaps.
        for (int i = 0; i < 300; i++) begin
            ra = pick();
            rb = ($urandom_range(7) == 0) ? ra : pick();
            if ($urandom_range(3) == 0) idle();
            issue_rand(ra, rb);
        end
        repeat (3) idle();

        check_bit("scoreboard_drained", scb.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
